// File: rtl/request_conditioner.sv
// request_conditioner
//
// Conditions raw field inputs (vehicle sensors and pedestrian pushbuttons)
// before they reach the intersection control FSM. Each channel is
// synchronised, debounced, edge-detected and turned into a sticky request
// that the FSM clears with a one-cycle acknowledge.
//
// Ports:
//   CLK       10 kHz clock, all logic on the rising edge
//   reset     asynchronous, active-high; clears all state
//   en        request-latch enable; low blocks new requests only
//   raw_in    unsynchronised field inputs, active-high
//   ack       per-channel one-cycle request clear from the FSM
//   level     debounced level
//   rise      one-cycle pulse on a debounced rising edge
//   req       sticky pending request
//   wait_led  pushbutton "wait" indicator drive, identical to req

module request_conditioner #(
    parameter int N_IN           = 6,
    parameter int DEBOUNCE_TICKS = 200,
    parameter int CNT_W          = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            en,
    input  logic [N_IN-1:0] raw_in,
    input  logic [N_IN-1:0] ack,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] req,
    output logic [N_IN-1:0] wait_led
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] accept;
    logic [N_IN-1:0] level_d;
    logic [N_IN-1:0] rise_next;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Per-channel stability counter. It only runs while the synchronised
    // input disagrees with the accepted level, and the level flips on the
    // cycle the disagreement has lasted DEBOUNCE_TICKS samples.
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        assign accept[i] = (sync2[i] != level[i]) && (cnt == CNT_LAST);

        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if ((sync2[i] == level[i]) || (cnt == CNT_LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // level_d lags level by one cycle so the edge pulse lands in the cycle
    // after level changes.
    assign rise_next = level & ~level_d;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            level   <= '0;
            level_d <= '0;
            rise    <= '0;
            req     <= '0;
        end else begin
            level   <= level ^ accept;
            level_d <= level;
            rise    <= rise_next;
            // Set takes priority over a simultaneous ack, so a press that
            // arrives in the ack cycle is not lost.
            req     <= (rise_next & {N_IN{en}}) | (req & ~ack);
        end
    end

    assign wait_led = req;

endmodule

// File: tb/tb_request_conditioner.sv
// Testbench for request_conditioner (DEBOUNCE_TICKS=4, CNT_W=3, N_IN=6).
// A directed vector table, hand-written multi-cycle sequences and a
// randomised phase, all continuously compared against a reference model.

module tb_request_conditioner;

    localparam int N = 6;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic         en;
    logic [N-1:0] raw_in;
    logic [N-1:0] ack;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] req;
    logic [N-1:0] wait_led;

    int n_cmp = 0;
    int n_bad = 0;

    request_conditioner #(.N_IN(N), .DEBOUNCE_TICKS(D), .CNT_W(3)) dut (
        .CLK(CLK), .reset(reset), .en(en), .raw_in(raw_in), .ack(ack),
        .level(level), .rise(rise), .req(req), .wait_led(wait_led)
    );

    always #50 CLK = ~CLK;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: level flips once the last D synchronised samples all
    // disagree with it; rise follows a 0->1 flip by one cycle; requests are
    // set by rise while enabled, otherwise cleared by ack.
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_req, m_rose, m_nl;
    logic [D-1:0] m_hist [N];

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_req = '0; m_rose = '0;
            for (int c = 0; c < N; c++) m_hist[c] = '0;
        end else begin
            m_nl = m_level;
            for (int c = 0; c < N; c++) begin
                m_hist[c] = {m_hist[c][D-2:0], m_s2[c]};
                if (m_hist[c] == {D{~m_level[c]}}) m_nl[c] = ~m_level[c];
            end
            m_rise = m_rose;
            m_rose = m_nl & ~m_level;
            for (int c = 0; c < N; c++) begin
                if (m_rise[c] && en) m_req[c] = 1'b1;
                else if (ack[c])     m_req[c] = 1'b0;
            end
            m_level = m_nl;
            m_s2 = m_s1;
            m_s1 = raw_in;
        end
    end

    always @(negedge CLK) begin
        chk("model_level", level, m_level);
        chk("model_rise", rise, m_rise);
        chk("model_req", req, m_req);
        chk("model_wait_led", wait_led, m_req);
    end

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] ack;
        logic         en;
        int           cycles;
        logic [N-1:0] lvl;
        logic [N-1:0] rs;
        logic [N-1:0] rq;
    } vec_t;

    vec_t tbl [16];

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        // basic latency on ch3
        tbl[0]  = '{6'h00, 6'h00, 1'b1, 3, 6'h00, 6'h00, 6'h00};
        tbl[1]  = '{6'h08, 6'h00, 1'b1, 5, 6'h00, 6'h00, 6'h00};
        tbl[2]  = '{6'h08, 6'h00, 1'b1, 1, 6'h08, 6'h00, 6'h00};
        tbl[3]  = '{6'h08, 6'h00, 1'b1, 1, 6'h08, 6'h08, 6'h08};
        tbl[4]  = '{6'h08, 6'h00, 1'b1, 1, 6'h08, 6'h00, 6'h08};
        // ch0 glitch of 3 cycles rejected
        tbl[5]  = '{6'h09, 6'h00, 1'b1, 3, 6'h08, 6'h00, 6'h08};
        tbl[6]  = '{6'h08, 6'h00, 1'b1, 6, 6'h08, 6'h00, 6'h08};
        // ch0 pulse of 4 cycles accepted
        tbl[7]  = '{6'h09, 6'h00, 1'b1, 4, 6'h08, 6'h00, 6'h08};
        tbl[8]  = '{6'h08, 6'h00, 1'b1, 2, 6'h09, 6'h00, 6'h08};
        tbl[9]  = '{6'h08, 6'h00, 1'b1, 1, 6'h09, 6'h01, 6'h09};
        tbl[10] = '{6'h08, 6'h00, 1'b1, 1, 6'h09, 6'h00, 6'h09};
        tbl[11] = '{6'h08, 6'h00, 1'b1, 2, 6'h08, 6'h00, 6'h09};
        // acks: pending ch0, idle, non-pending ch1, pending ch3
        tbl[12] = '{6'h08, 6'h01, 1'b1, 1, 6'h08, 6'h00, 6'h08};
        tbl[13] = '{6'h08, 6'h00, 1'b1, 1, 6'h08, 6'h00, 6'h08};
        tbl[14] = '{6'h08, 6'h02, 1'b1, 1, 6'h08, 6'h00, 6'h08};
        tbl[15] = '{6'h08, 6'h08, 1'b1, 1, 6'h08, 6'h00, 6'h00};

        reset = 1'b1; en = 1'b1; raw_in = '0; ack = '0;
        #1;
        chk("reset_level", level, 6'h00);
        chk("reset_rise", rise, 6'h00);
        chk("reset_req", req, 6'h00);
        chk("reset_wait_led", wait_led, 6'h00);
        step(3);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            raw_in = tbl[i].raw; ack = tbl[i].ack; en = tbl[i].en;
            step(tbl[i].cycles);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rs);
            chk($sformatf("tbl%0d_req", i), req, tbl[i].rq);
            chk($sformatf("tbl%0d_wait_led", i), wait_led, tbl[i].rq);
        end
        ack = '0;

        // set/ack collision on ch5
        raw_in = 6'h00; step(10);
        raw_in = 6'h20; step(6);
        ack = 6'h20; step(1); ack = '0;
        chk("coll_rise", rise, 6'h20);
        chk("coll_req", req, 6'h20);
        step(1);
        chk("coll_req_hold", req, 6'h20);
        ack = 6'h20; step(1); ack = '0;
        chk("coll_req_clr", req, 6'h00);

        // handshake on ch4, ack on non-pending ch0
        raw_in = 6'h30; step(7);
        chk("hs_req_set", req, 6'h10);
        ack = 6'h01; step(1); ack = '0;
        chk("hs_nonpend", req, 6'h10);
        ack = 6'h10; step(1); ack = '0;
        chk("hs_req_clr", req, 6'h00);
        chk("hs_led_clr", wait_led, 6'h00);

        // enable gating
        raw_in = 6'h34; step(7);
        chk("en_pre_req", req, 6'h04);
        en = 1'b0; raw_in = 6'h36; step(6);
        chk("en_level", level, 6'h36);
        step(1);
        chk("en_rise", rise, 6'h02);
        chk("en_req_gated", req, 6'h04);
        en = 1'b1; step(5);
        chk("en_no_late_req", req, 6'h04);
        ack = 6'h04; step(1); ack = '0;
        chk("en_ack_held", req, 6'h00);
        raw_in = 6'h34; step(10);
        chk("en_release", level, 6'h34);
        raw_in = 6'h36; step(7);
        chk("en_repress_req", req, 6'h02);
        chk("en_repress_rise", rise, 6'h02);

        // async reset between rise and ack, inputs held high
        step(1);
        #20 reset = 1'b1;
        #1;
        chk("arst_level", level, 6'h00);
        chk("arst_rise", rise, 6'h00);
        chk("arst_req", req, 6'h00);
        chk("arst_wait_led", wait_led, 6'h00);
        step(1);
        reset = 1'b0;
        step(5);
        chk("arst_level_5", level, 6'h00);
        step(1);
        chk("arst_level_6", level, 6'h36);
        step(1);
        chk("arst_rise_7", rise, 6'h36);
        chk("arst_req_7", req, 6'h36);
        step(1);
        chk("arst_rise_8", rise, 6'h00);

        // randomised traffic, checked by the model every cycle
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) raw_in[b] = ~raw_in[b];
            ack = N'($urandom & $urandom);
            en  = ($urandom_range(0, 7) != 0);
            step(1);
        end
        ack = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
